// File: rtl/msrv32_fetch_decode_ctrl_if.sv
// Fetch/decode controller bus: instruction-memory handshake, pipeline control and decoded outputs.
// master is the controller itself, slave is the surrounding core / memory side.
interface msrv32_fetch_decode_ctrl_if;
   logic        start_in;
   logic        imem_ready_in;
   logic [31:0] imem_rdata_in;
   logic        stall_in;
   logic        flush_in;
   logic        branch_taken_in;
   logic [31:0] branch_target_in;
   logic        imem_req_out;
   logic [31:0] imem_addr_out;
   logic [31:0] pc_out;
   logic [24:0] instr_out;
   logic [2:0]  imm_type_out;
   logic [6:0]  opcode_out;
   logic        instr_valid_out;
   logic        illegal_out;
   logic        fetch_err_out;

   modport master (
      input  start_in, imem_ready_in, imem_rdata_in, stall_in, flush_in,
             branch_taken_in, branch_target_in,
      output imem_req_out, imem_addr_out, pc_out, instr_out, imm_type_out,
             opcode_out, instr_valid_out, illegal_out, fetch_err_out
   );

   modport slave (
      output start_in, imem_ready_in, imem_rdata_in, stall_in, flush_in,
             branch_taken_in, branch_target_in,
      input  imem_req_out, imem_addr_out, pc_out, instr_out, imm_type_out,
             opcode_out, instr_valid_out, illegal_out, fetch_err_out
   );
endinterface

// File: rtl/msrv32_fetch_decode_ctrl.sv
// IDLE/FETCH/VALID fetch controller with opcode -> immediate-type decode; ready-to-valid latency 1 cycle,
// stall_in holds the instruction. MSRV32_FETCH_TIMEOUT_EN adds a 16-cycle fetch timeout to IDLE.
module msrv32_fetch_decode_ctrl #(
   parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
   input logic clk_in,
   input logic rst_in,
   msrv32_fetch_decode_ctrl_if.master bus
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] VALID = 2'd2;

   logic [1:0]  state;
   logic [31:0] pc;
   logic [31:0] instr;
   logic [31:0] redirect;
   logic [2:0]  imm_type;
   logic        legal;

   assign redirect = {bus.branch_target_in[31:2], 2'b00};

`ifdef MSRV32_FETCH_TIMEOUT_EN
   logic [3:0] wait_cnt;
   logic       fetch_err;
`endif

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state <= IDLE;
         pc    <= BOOT_ADDR;
         instr <= 32'h0;
`ifdef MSRV32_FETCH_TIMEOUT_EN
         wait_cnt  <= 4'd0;
         fetch_err <= 1'b0;
`endif
      end else begin
`ifdef MSRV32_FETCH_TIMEOUT_EN
         fetch_err <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (bus.start_in) begin
                  state <= FETCH;
                  pc    <= BOOT_ADDR;
`ifdef MSRV32_FETCH_TIMEOUT_EN
                  wait_cnt <= 4'd0;
`endif
               end
            end
            FETCH: begin
               // Flush outranks a completing fetch: the returned word is dropped.
               if (bus.flush_in) begin
                  pc <= redirect;
`ifdef MSRV32_FETCH_TIMEOUT_EN
                  wait_cnt <= 4'd0;
`endif
               end else if (bus.imem_ready_in) begin
                  state <= VALID;
                  instr <= bus.imem_rdata_in;
               end
`ifdef MSRV32_FETCH_TIMEOUT_EN
               else if (wait_cnt == 4'd15) begin
                  state     <= IDLE;
                  fetch_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
`endif
            end
            VALID: begin
               if (bus.flush_in) begin
                  state <= FETCH;
                  pc    <= redirect;
`ifdef MSRV32_FETCH_TIMEOUT_EN
                  wait_cnt <= 4'd0;
`endif
               end else if (!bus.stall_in) begin
                  state <= FETCH;
                  pc    <= bus.branch_taken_in ? redirect : pc + 32'd4;
`ifdef MSRV32_FETCH_TIMEOUT_EN
                  wait_cnt <= 4'd0;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      imm_type = 3'b000;
      legal    = 1'b1;
      case (instr[6:0])
         7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111: imm_type = 3'b001;
         7'b0100011: imm_type = 3'b010;
         7'b1100011: imm_type = 3'b011;
         7'b0110111, 7'b0010111: imm_type = 3'b100;
         7'b1101111: imm_type = 3'b101;
         7'b1110011: imm_type = 3'b110;
         7'b0110011: imm_type = 3'b000;
         default:    legal    = 1'b0;
      endcase
   end

   assign bus.imem_req_out    = (state == FETCH);
   assign bus.imem_addr_out   = pc;
   assign bus.pc_out          = pc;
   assign bus.instr_out       = instr[31:7];
   assign bus.opcode_out      = instr[6:0];
   assign bus.imm_type_out    = imm_type;
   assign bus.instr_valid_out = (state == VALID);
   assign bus.illegal_out     = (state == VALID) && !legal;
`ifdef MSRV32_FETCH_TIMEOUT_EN
   assign bus.fetch_err_out   = fetch_err;
`else
   assign bus.fetch_err_out   = 1'b0;
`endif
endmodule

// File: tb/tb_msrv32_fetch_decode_ctrl.sv
// Directed scenarios plus randomized traffic against a behavioural model of the fetch controller.
module tb_msrv32_fetch_decode_ctrl;
   logic clk_in = 1'b0;
   logic rst_in = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   msrv32_fetch_decode_ctrl_if bus();

   msrv32_fetch_decode_ctrl #(.BOOT_ADDR(32'h0000_0000)) dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .bus(bus)
   );

   always #5 clk_in = ~clk_in;

`ifdef MSRV32_FETCH_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif

   // Model: running = started and not timed out, have = an instruction is being held.
   bit          m_running;
   bit          m_have;
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   int          m_misses;
   bit          m_err;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Returns {legal, imm_type} for an opcode, straight from the opcode table.
   function automatic logic [3:0] ref_decode(input logic [6:0] op);
      if (op == 7'h03 || op == 7'h13 || op == 7'h67 || op == 7'h0F) return 4'b1001;
      if (op == 7'h23) return 4'b1010;
      if (op == 7'h63) return 4'b1011;
      if (op == 7'h37 || op == 7'h17) return 4'b1100;
      if (op == 7'h6F) return 4'b1101;
      if (op == 7'h73) return 4'b1110;
      if (op == 7'h33) return 4'b1000;
      return 4'b0000;
   endfunction

   task automatic model_reset();
      m_running = 0; m_have = 0; m_pc = 32'h0; m_instr = 32'h0; m_misses = 0; m_err = 0;
   endtask

   task automatic model_step();
      m_err = 0;
      if (!m_running) begin
         if (bus.start_in) begin
            m_running = 1; m_have = 0; m_pc = 32'h0; m_misses = 0;
         end
      end else if (bus.flush_in) begin
         m_have = 0; m_pc = bus.branch_target_in & 32'hFFFF_FFFC; m_misses = 0;
      end else if (!m_have) begin
         if (bus.imem_ready_in) begin
            m_have = 1; m_instr = bus.imem_rdata_in;
         end else if (TIMEOUT_EN) begin
            m_misses++;
            if (m_misses == 16) begin
               m_running = 0; m_err = 1;
            end
         end
      end else if (!bus.stall_in) begin
         m_have = 0; m_misses = 0;
         m_pc = bus.branch_taken_in ? (bus.branch_target_in & 32'hFFFF_FFFC) : m_pc + 32'd4;
      end
   endtask

   task automatic check_all(input string tag);
      logic [3:0] d;
      d = ref_decode(m_instr[6:0]);
      check({tag, ".req"},     {31'd0, bus.imem_req_out},    {31'd0, m_running && !m_have});
      check({tag, ".addr"},    bus.imem_addr_out,            m_pc);
      check({tag, ".pc"},      bus.pc_out,                   m_pc);
      check({tag, ".valid"},   {31'd0, bus.instr_valid_out}, {31'd0, m_running && m_have});
      check({tag, ".instr"},   {7'd0, bus.instr_out},        {7'd0, m_instr[31:7]});
      check({tag, ".opcode"},  {25'd0, bus.opcode_out},      {25'd0, m_instr[6:0]});
      check({tag, ".imm"},     {29'd0, bus.imm_type_out},    {29'd0, d[2:0]});
      check({tag, ".illegal"}, {31'd0, bus.illegal_out},     {31'd0, m_running && m_have && !d[3]});
      check({tag, ".err"},     {31'd0, bus.fetch_err_out},   {31'd0, m_err});
   endtask

   // Drive inputs at the falling edge, step the model, then compare at the next falling edge.
   task automatic tick(input string tag, input logic s, input logic r, input logic [31:0] d,
                       input logic st, input logic fl, input logic br, input logic [31:0] t);
      bus.start_in = s; bus.imem_ready_in = r; bus.imem_rdata_in = d; bus.stall_in = st;
      bus.flush_in = fl; bus.branch_taken_in = br; bus.branch_target_in = t;
      model_step();
      @(negedge clk_in);
      check_all(tag);
   endtask

   task automatic do_reset();
      rst_in = 1'b1;
      model_reset();
      tick("rst", 0, 0, 0, 0, 0, 0, 0);
      rst_in = 1'b0;
   endtask

   function automatic logic [31:0] rand_word();
      logic [6:0] ops [11];
      logic [31:0] w;
      ops = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33};
      w = $urandom;
      if ($urandom_range(0, 3) != 0) w[6:0] = ops[$urandom_range(0, 10)];
      return w;
   endfunction

   initial begin
      bus.start_in = 0; bus.imem_ready_in = 0; bus.imem_rdata_in = 0; bus.stall_in = 0;
      bus.flush_in = 0; bus.branch_taken_in = 0; bus.branch_target_in = 0;
      model_reset();
      @(negedge clk_in);
      check_all("reset");
      do_reset();

      // Boot fetch of addi x1,x0,10.
      tick("start", 1, 1, 32'h00A00093, 0, 0, 0, 0);
      check("s1_addr", bus.imem_addr_out, 32'h0);
      tick("fetch0", 0, 1, 32'h00A00093, 0, 0, 0, 0);
      check("s1_valid", {31'd0, bus.instr_valid_out}, 32'd1);
      check("s1_imm", {29'd0, bus.imm_type_out}, 32'd1);
      check("s1_op", {25'd0, bus.opcode_out}, 32'h13);
      tick("adv0", 0, 0, 0, 0, 0, 0, 0);
      check("s1_pc4", bus.pc_out, 32'd4);

      // Stall holds a branch instruction for three cycles.
      tick("fetch1", 0, 1, 32'hFE000EE3, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         tick("stall", 0, 0, 32'h12345678, 1, 0, 1, 32'h40);
         check("s2_imm", {29'd0, bus.imm_type_out}, 32'd3);
         check("s2_pc", bus.pc_out, 32'd4);
      end
      tick("release", 0, 0, 0, 0, 0, 0, 0);
      check("s2_pc8", bus.imem_addr_out, 32'd8);

      // Taken branch to a misaligned target.
      tick("fetch2", 0, 1, 32'h00000013, 0, 0, 0, 0);
      tick("branch", 0, 0, 0, 0, 0, 1, 32'h0000_0102);
      check("s3_addr", bus.imem_addr_out, 32'h0000_0100);

      // Flush on the cycle a fetch completes.
      tick("flushrdy", 0, 1, 32'h00000013, 0, 1, 0, 32'h0000_0200);
      check("s4_valid", {31'd0, bus.instr_valid_out}, 32'd0);
      check("s4_addr", bus.imem_addr_out, 32'h0000_0200);

      // Illegal opcode at the top of the address space, then wrap.
      tick("flushtop", 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF);
      tick("fetchill", 0, 1, 32'h0000007F, 0, 0, 0, 0);
      check("s5_ill", {31'd0, bus.illegal_out}, 32'd1);
      check("s5_imm", {29'd0, bus.imm_type_out}, 32'd0);
      tick("wrap", 0, 0, 0, 0, 0, 0, 0);
      check("s5_pc0", bus.pc_out, 32'h0);

      // Flush is ignored in IDLE.
      do_reset();
      tick("idleflush", 0, 1, 32'h13, 0, 1, 1, 32'h80);
      check("idle_req", {31'd0, bus.imem_req_out}, 32'd0);

`ifdef MSRV32_FETCH_TIMEOUT_EN
      tick("tstart", 1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) tick("twait", 0, 0, 0, 0, 0, 0, 0);
      check("to_err", {31'd0, bus.fetch_err_out}, 32'd1);
      check("to_req", {31'd0, bus.imem_req_out}, 32'd0);
      tick("tafter", 0, 0, 0, 0, 0, 0, 0);
      check("to_pulse", {31'd0, bus.fetch_err_out}, 32'd0);
`endif

      // Asynchronous reset in the middle of a fetch.
      tick("rstart", 1, 0, 0, 0, 0, 0, 0);
      tick("rfetch", 0, 0, 0, 0, 0, 0, 0);
      #2 rst_in = 1'b1;
      #1;
      check("arst_req", {31'd0, bus.imem_req_out}, 32'd0);
      check("arst_valid", {31'd0, bus.instr_valid_out}, 32'd0);
      check("arst_pc", bus.pc_out, 32'h0);
      check("arst_err", {31'd0, bus.fetch_err_out}, 32'd0);
      model_reset();
      tick("arst", 0, 0, 0, 0, 0, 0, 0);
      rst_in = 1'b0;

      // Randomized traffic.
      tick("rnd_start", 1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 600; i++) begin
         tick("rnd", ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 6), rand_word(),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 2) == 0), $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/msrv32_fetch_decode_ctrl.md
MSRV32_FETCH_DECODE_CTRL -- requirements
Module: msrv32_fetch_decode_ctrl

Interface
REQ-001 The block SHALL have one parameter: BOOT_ADDR, default 32'h0000_0000, PC value loaded at reset and on start.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high; ports clk_in and rst_in.
REQ-003 The block SHALL have these ports:
- clk_in  in  1  rising-edge clock
- rst_in  in  1  async active-high reset
- start_in  in  1  leave IDLE and begin fetching at BOOT_ADDR
- imem_ready_in  in  1  instruction memory data valid this cycle
- imem_rdata_in  in  32  instruction word
- stall_in  in  1  hold the current instruction
- flush_in  in  1  discard the current instruction, redirect to branch_target_in
- branch_taken_in  in  1  next PC is branch_target_in
- branch_target_in  in  32  redirect address
- imem_req_out  out  1  fetch request
- imem_addr_out  out  32  fetch address, equal to pc_out
- pc_out  out  32  PC of the held or pending instruction
- instr_out  out  25  held instruction bits [31:7], feeding msrv32_imm_generator instr_in
- imm_type_out  out  3  immediate type, feeding imm_type_in
- opcode_out  out  7  held instruction bits [6:0]
- instr_valid_out  out  1  instr_out, imm_type_out and opcode_out are valid
- illegal_out  out  1  held opcode is not RV32I
- fetch_err_out  out  1  one-cycle fetch timeout pulse

Function
REQ-004 The FSM SHALL have three states, IDLE, FETCH and VALID, and SHALL move between them as follows:
- IDLE to FETCH on start_in, with pc loaded to BOOT_ADDR.
- FETCH to VALID when imem_ready_in=1; instr register <= imem_rdata_in in that cycle.
- VALID to FETCH when stall_in=0.
REQ-005 In FETCH, imem_req_out SHALL be 1 and imem_addr_out SHALL equal pc; in all other states imem_req_out SHALL be 0.
REQ-006 instr_valid_out SHALL be 1 only in VALID, one cycle after the accepting edge, so the latency from ready to valid is 1 cycle.
REQ-007 In VALID with stall_in=1, all held outputs and pc SHALL stay unchanged.
REQ-008 On leaving VALID, pc SHALL be updated as follows:
- pc <= {branch_target_in[31:2],2'b00} if branch_taken_in=1.
- pc <= pc+4 otherwise, wrapping modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0).
REQ-009 flush_in=1 in FETCH or VALID SHALL, at the next edge, force the FSM to FETCH, set pc <= {branch_target_in[31:2],2'b00} and clear instr_valid_out. This SHALL hold even when a fetch completes in the same cycle, in which case the returned word is dropped.
REQ-010 Priority SHALL be flush_in > stall_in > branch_taken_in > sequential; flush_in in IDLE SHALL be ignored.
REQ-011 imm_type_out SHALL decode from the held opcode as follows, combinational from the instr register:
- 0000011, 0010011, 1100111, 0001111 -> 3'b001 (I)
- 0100011 -> 3'b010 (S)
- 1100011 -> 3'b011 (B)
- 0110111, 0010111 -> 3'b100 (U)
- 1101111 -> 3'b101 (J)
- 1110011 -> 3'b110 (CSR)
- 0110011 -> 3'b000
REQ-012 Any other opcode SHALL give imm_type_out=3'b000 and illegal_out=1 while instr_valid_out=1; illegal_out SHALL be 0 whenever instr_valid_out=0.

Reset
REQ-013 rst_in=1 SHALL immediately force the following, regardless of state or any in-flight fetch:
- state IDLE, pc=BOOT_ADDR, instr register=32'h0
- imem_req_out=0, instr_valid_out=0, illegal_out=0, fetch_err_out=0, imm_type_out=3'b000
REQ-014 After rst_in falls, the block SHALL stay in IDLE until start_in=1.

Configuration
REQ-015 With MSRV32_FETCH_TIMEOUT_EN defined, the block SHALL behave as follows:
- A 4-bit counter clears on entry to FETCH and increments each FETCH cycle with imem_ready_in=0.
- The 16th consecutive non-ready cycle pulses fetch_err_out for one cycle and returns the FSM to IDLE, dropping imem_req_out.
- pc is retained.
- flush_in on the same cycle wins; no error is raised.
REQ-016 Without MSRV32_FETCH_TIMEOUT_EN, FETCH SHALL wait indefinitely, fetch_err_out SHALL be constant 0 and no counter logic SHALL exist.

Verification
REQ-017 The bench SHALL cover these scenarios:
- Reset, then start_in with imem_ready_in=1 and rdata 32'h00A00093 -> imem_addr_out=0, next cycle instr_valid_out=1, imm_type_out=001, opcode_out=7'h13, then pc_out=4.
- VALID with stall_in=1 for 3 cycles, rdata 32'hFE000EE3 -> outputs frozen, imm_type_out=011; release -> FETCH at pc+4.
- VALID with branch_taken_in=1 and target 32'h0000_0102 -> next imem_addr_out=32'h0000_0100.
- flush_in asserted on the same cycle imem_ready_in=1 -> word discarded, instr_valid_out=0, FETCH at the flush target.
- Opcode 7'b1111111 -> illegal_out=1, imm_type_out=000; pc=32'hFFFF_FFFC advances to 32'h0.
- With MSRV32_FETCH_TIMEOUT_EN, imem_ready_in held 0 -> fetch_err_out pulses on the 16th cycle and the FSM is in IDLE; rst_in mid-FETCH -> all outputs clear immediately.
